// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit serializer, the baud
// generator and the receive path.
//   tx_state_t  : transmit FSM state encoding
//   CLK_FREQ_HZ, BAUD_RATE, BAUD_DIV : baud constants shared with the generator
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned CLK_FREQ_HZ = 100_000_000;
   localparam int unsigned BAUD_RATE   = 115_200;
   localparam int unsigned BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

endpackage

// File: rtl/uart_edge_sync.sv
// Two-flop synchronizer plus edge register for a slow clock-like input that
// is sampled as data. Produces a one-clk pulse per rising edge of i_d,
// 2-3 clk after the edge.
//   i_clk   : system clock
//   i_rst   : asynchronous active-low reset
//   i_d     : asynchronous input level
//   o_rise  : one-clk rising-edge pulse
module uart_edge_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_rise
);

   // [0],[1] are the synchronizer, [2] is the edge-detect history
   logic [2:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_sync <= '0;
      else        r_sync <= {r_sync[1:0], i_d};
   end

   assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer. Each rising edge of i_tx_clk (one bit period)
// advances the frame: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits.
//   i_clk     : system clock
//   i_rst     : asynchronous active-low reset
//   i_tx_clk  : bit-rate clock from the baud generator, sampled as data
//   i_newd    : send request, accepted only while idle
//   i_tx_data : byte captured on the accept cycle
//   o_tx      : serial line, idle high
//   o_busy    : frame in progress
//   o_donetx  : one-clk pulse when the last stop bit period ends
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tx_clk,
   input  logic              i_newd,
   input  logic [DATA_W-1:0] i_tx_data,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_donetx
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   tx_state_t          r_state;
   tx_state_t          w_state_nxt;
   logic [DATA_W-1:0]  r_shreg;
   logic               r_par;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_tx;
   logic               r_busy;
   logic               r_done;
   logic               w_tx_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_tick;
   logic               w_accept;
   logic               w_last_data;
   logic               w_last_stop;

   uart_edge_sync u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (i_tx_clk),
      .o_rise (w_tick)
   );

   assign w_accept    = (r_state == IDLE) & i_newd;
   assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
   // STOP counts STOP_BITS ticks that begin stop bits, then one more that ends the last
   assign w_last_stop = (r_cnt == CNT_W'(STOP_BITS));

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state. Each state names the bit that begins on the next tick.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = START;
         START:   if (w_tick) w_state_nxt = DATA;
         DATA:    if (w_tick && w_last_data)
                     w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (w_tick) w_state_nxt = STOP;
         STOP:    if (w_tick && w_last_stop) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output values for the next cycle; line level only moves on a tick
   always_comb begin
      w_tx_nxt   = r_tx;
      w_busy_nxt = r_busy;
      w_done_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_accept) w_busy_nxt = 1'b1;
         end
         START:  if (w_tick) w_tx_nxt = 1'b0;
         DATA:   if (w_tick) w_tx_nxt = r_shreg[0];
         PARITY: if (w_tick) w_tx_nxt = r_par;
         STOP: begin
            if (w_tick) begin
               w_tx_nxt = 1'b1;
               if (w_last_stop) begin
                  w_busy_nxt = 1'b0;
                  w_done_nxt = 1'b1;
               end
            end
         end
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_shreg <= '0;
         r_par   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_shreg <= i_tx_data;
            r_par   <= (^i_tx_data) ^ 1'(PARITY_ODD);
         end else if (r_state == DATA && w_tick) begin
            r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
         end
         // Shared counter: data bit index in DATA, stop tick index in STOP;
         // cleared whenever the state moves on
         if (w_tick) begin
            if ((r_state == DATA || r_state == STOP) && w_state_nxt == r_state)
               r_cnt <= r_cnt + CNT_W'(1);
            else
               r_cnt <= '0;
         end
      end
   end

   assign o_tx     = r_tx;
   assign o_busy   = r_busy;
   assign o_donetx = r_done;

endmodule
